// File: rtl/bcd_xs3_seq_conv.sv
`default_nettype none
// ============================================================================
// Module   : bcd_xs3_seq_conv
// Purpose  : Multi-digit BCD <-> Excess-3 sequential converter with valid/ready
//            handshakes, LSD first, DPC digits per clock, illegal-code flags.
// Revision : 1.0
// ============================================================================
module bcd_xs3_seq_conv #(
    parameter int DIGITS = 4,
    parameter int DPC    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_data,
    input  logic                mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_data,
    output logic                err,
    output logic [DIGITS-1:0]   err_mask,
    output logic                busy
);

    localparam int STEPS = DIGITS / DPC;
    localparam int CW    = $clog2(STEPS + 1);

    if ((DIGITS < 1) || (DPC < 1) || ((DIGITS % DPC) != 0)) begin : g_bad_params
        $error("bcd_xs3_seq_conv: DIGITS must be >= 1 and an exact multiple of DPC");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [4*DIGITS-1:0] src_q;
    logic                mode_q;
    logic [4*DIGITS-1:0] data_q;
    logic [4*DIGITS-1:0] data_d;
    logic [DIGITS-1:0]   mask_q;
    logic [DIGITS-1:0]   mask_d;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    logic [4*DIGITS-1:0] conv_nib;
    logic [DIGITS-1:0]   conv_bad;

    // Every digit is converted in parallel; the counter only picks which
    // results get committed on a given cycle.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] d;
        assign d           = src_q[4*g +: 4];
        assign conv_bad[g] = mode_q ? ((d < 4'd3) || (d > 4'd12)) : (d > 4'd9);
        assign conv_nib[4*g +: 4] = conv_bad[g] ? 4'hF :
                                    (mode_q ? (d - 4'd3) : (d + 4'd3));
    end

    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i / DPC)) begin
                data_d[4*i +: 4] = conv_nib[4*i +: 4];
                mask_d[i]        = conv_bad[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            src_q       <= '0;
            mode_q      <= 1'b0;
            data_q      <= '0;
            mask_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        src_q      <= in_data;
                        mode_q     <= mode;
                        data_q     <= '0;
                        mask_q     <= '0;
                        cnt_q      <= '0;
                        state_q    <= S_CONV;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_CONV: begin
                    // One extra cycle after the last slice before DONE.
                    if (cnt_q == CW'(STEPS)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        data_q <= data_d;
                        mask_q <= mask_d;
                        cnt_q  <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign err_mask  = mask_q;
    assign err       = |mask_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_xs3_seq_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_xs3_seq_conv
// Purpose  : Directed self-checking bench for bcd_xs3_seq_conv (4x1 and 8x2).
// Revision : 1.0
// ============================================================================
module tb_bcd_xs3_seq_conv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready, a_err, a_busy;
    logic [15:0] a_in_data, a_out_data;
    logic [3:0]  a_err_mask;
    logic        b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_err, b_busy;
    logic [31:0] b_in_data, b_out_data;
    logic [7:0]  b_err_mask;

    int checks = 0;
    int errors = 0;
    int lat;

    bcd_xs3_seq_conv #(.DIGITS(4), .DPC(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .mode(a_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .err(a_err), .err_mask(a_err_mask), .busy(a_busy)
    );

    bcd_xs3_seq_conv #(.DIGITS(8), .DPC(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .mode(b_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .err(b_err), .err_mask(b_err_mask), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a word for one edge, then scramble the inputs to show they are ignored.
    task automatic send_a(input logic m, input logic [15:0] d);
        @(negedge clk);
        a_mode = m; a_in_data = d; a_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0; a_mode = ~m; a_in_data = ~d;
    endtask

    task automatic wait_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_out_valid && n < 20);
    endtask

    task automatic xfer_a(input string tag, input logic m, input logic [15:0] d,
                          input logic [15:0] exp_d, input logic [3:0] exp_m);
        int n;
        send_a(m, d);
        wait_a(n);
        chk({tag, "_lat"},  n, 5);
        chk({tag, "_data"}, a_out_data, exp_d);
        chk({tag, "_mask"}, a_err_mask, exp_m);
        chk({tag, "_err"},  a_err, |exp_m);
        chk({tag, "_nordy"}, a_in_ready, 1'b0);
        @(negedge clk);
        chk({tag, "_vld1cyc"}, a_out_valid, 1'b0);
        chk({tag, "_idle"},    a_in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_mode = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_mode = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        #12;
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_out_data", a_out_data, 16'h0000);
        chk("rst_err_mask", a_err_mask, 4'h0);
        chk("rst_b_out_valid", b_out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Basic conversions and round trip
        xfer_a("t1_1234", 1'b0, 16'h1234, 16'h4567, 4'b0000);
        xfer_a("t2_3c3c", 1'b1, 16'h3C3C, 16'h0909, 4'b0000);
        xfer_a("t2_9999", 1'b0, 16'h9999, 16'hCCCC, 4'b0000);
        xfer_a("t2_cccc", 1'b1, 16'hCCCC, 16'h9999, 4'b0000);

        // Illegal source codes
        xfer_a("t3_12a4", 1'b0, 16'h12A4, 16'h45F7, 4'b0010);
        xfer_a("t3_0d36", 1'b1, 16'h0D36, 16'hFF03, 4'b1100);

        // Backpressure in DONE with a competing in_valid
        a_out_ready = 1'b0;
        send_a(1'b0, 16'h0123);
        wait_a(lat);
        chk("t4_lat", lat, 5);
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1; a_in_data = 16'h5555; a_mode = 1'b0;
            @(negedge clk);
            chk("t4_hold_valid", a_out_valid, 1'b1);
            chk("t4_hold_data", a_out_data, 16'h3456);
            chk("t4_hold_mask", a_err_mask, 4'b0000);
            chk("t4_hold_ready", a_in_ready, 1'b0);
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("t4_release_valid", a_out_valid, 1'b0);
        chk("t4_release_ready", a_in_ready, 1'b1);
        chk("t4_release_busy", a_busy, 1'b0);
        chk("t4_keep_data", a_out_data, 16'h3456);
        xfer_a("t4_next", 1'b1, 16'h4567, 16'h1234, 4'b0000);

        // Asynchronous reset two cycles into CONV
        send_a(1'b0, 16'hAAAA);
        @(negedge clk);
        @(negedge clk);
        chk("t5_partial_mask", a_err_mask, 4'b0011);
        chk("t5_busy_before", a_busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_valid", a_out_valid, 1'b0);
        chk("t5_rst_busy", a_busy, 1'b0);
        chk("t5_rst_mask", a_err_mask, 4'b0000);
        chk("t5_rst_data", a_out_data, 16'h0000);
        chk("t5_rst_ready", a_in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        xfer_a("t5_0000", 1'b0, 16'h0000, 16'h3333, 4'b0000);

        // Wide instance, two digits per clock
        @(negedge clk);
        b_mode = 1'b0; b_in_data = 32'h98765432; b_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0; b_in_data = 32'hFFFFFFFF; b_mode = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!b_out_valid && lat < 20);
        chk("t6_lat", lat, 5);
        chk("t6_data", b_out_data, 32'hCBA98765);
        chk("t6_mask", b_err_mask, 8'h00);
        @(negedge clk);
        chk("t6_vld1cyc", b_out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
